// File: rtl/bus_reg_universal.sv
// bus_reg_universal: mode-selected register/counter/shifter with bus output-enable; parity output enabled by BUS_REG_UNIVERSAL_PARITY_EN
module bus_reg_universal #(
  parameter int WIDTH = 8,
  parameter int NUM_OE = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              en_n,
  input  logic [2:0]        mode,
  input  logic [WIDTH-1:0]  d,
  input  logic              ser_in,
  input  logic [NUM_OE-1:0] oe_n,
  output logic [WIDTH-1:0]  q,
  output logic              oe_out_n,
  output logic              co,
  output logic              zero,
  output logic              par
);
  localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);
  logic [WIDTH-1:0] q_q, q_d;
  logic             co_q, co_d;
  always_comb begin
    q_d  = q_q;
    co_d = co_q;
    if (!en_n) begin
      case (mode)
        3'b000: begin q_d = q_q; co_d = co_q; end
        3'b001: begin q_d = d; co_d = 1'b0; end
        3'b010: {co_d, q_d} = {1'b0, q_q} + ONE;
        3'b011: {co_d, q_d} = {1'b0, q_q} - ONE;
        3'b100: begin q_d = {q_q[WIDTH-2:0], ser_in}; co_d = q_q[WIDTH-1]; end
        3'b101: begin q_d = {ser_in, q_q[WIDTH-1:1]}; co_d = q_q[0]; end
        3'b110: begin q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]}; co_d = q_q[WIDTH-1]; end
        default: begin q_d = RESET_VALUE; co_d = 1'b0; end
      endcase
    end
  end
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      q_q  <= RESET_VALUE;
      co_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      co_q <= co_d;
    end
  end
  assign q        = q_q;
  assign co       = co_q;
  assign zero     = (q_q == '0);
  assign oe_out_n = |oe_n;
`ifdef BUS_REG_UNIVERSAL_PARITY_EN
  assign par = ^q_q;
`else
  assign par = 1'b0;
`endif
endmodule

// File: tb/tb_bus_reg_universal.sv
// tb_bus_reg_universal: directed self-checking bench for bus_reg_universal (RESET_VALUE=8'hA5)
module tb_bus_reg_universal;
  logic       clk = 1'b0;
  logic       clr_n = 1'b1;
  logic       en_n = 1'b1;
  logic [2:0] mode = 3'b000;
  logic [7:0] d = 8'h00;
  logic       ser_in = 1'b0;
  logic [1:0] oe_n = 2'b11;
  logic [7:0] q;
  logic       oe_out_n, co, zero, par;
  int errors = 0;
  int checks = 0;

  bus_reg_universal #(.WIDTH(8), .NUM_OE(2), .RESET_VALUE(8'hA5)) dut (
    .clk(clk), .clr_n(clr_n), .en_n(en_n), .mode(mode), .d(d), .ser_in(ser_in),
    .oe_n(oe_n), .q(q), .oe_out_n(oe_out_n), .co(co), .zero(zero), .par(par)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    en_n = 1'b0; mode = 3'b001; d = v;
    tick();
  endtask

  task automatic test_reset();
    #1 clr_n = 1'b0;
    #1;
    checks++; if (q !== 8'hA5) begin errors++; $display("FAIL por_q got %h exp a5", q); end
    checks++; if (co !== 1'b0) begin errors++; $display("FAIL por_co got %b exp 0", co); end
    tick();
    clr_n = 1'b1;
    load(8'h3C);
    checks++; if (q !== 8'h3C) begin errors++; $display("FAIL pre_clr_q got %h exp 3c", q); end
    #2 clr_n = 1'b0;
    #1;
    checks++; if (q !== 8'hA5) begin errors++; $display("FAIL async_clr_q got %h exp a5", q); end
    checks++; if (co !== 1'b0) begin errors++; $display("FAIL async_clr_co got %b exp 0", co); end
    en_n = 1'b0; mode = 3'b001; d = 8'hFF;
    repeat (3) tick();
    checks++; if (q !== 8'hA5) begin errors++; $display("FAIL clr_hold_q got %h exp a5", q); end
    clr_n = 1'b1;
  endtask

  task automatic test_load_enable();
    load(8'h5A);
    checks++; if (q !== 8'h5A) begin errors++; $display("FAIL load_q got %h exp 5a", q); end
    checks++; if (co !== 1'b0) begin errors++; $display("FAIL load_co got %b exp 0", co); end
    checks++; if (zero !== 1'b0) begin errors++; $display("FAIL load_zero got %b exp 0", zero); end
    en_n = 1'b1; d = 8'h00;
    tick();
    checks++; if (q !== 8'h5A) begin errors++; $display("FAIL en_hold_q got %h exp 5a", q); end
    oe_n = 2'b00; #1;
    checks++; if (oe_out_n !== 1'b0) begin errors++; $display("FAIL oe00 got %b exp 0", oe_out_n); end
    oe_n = 2'b01; #1;
    checks++; if (oe_out_n !== 1'b1) begin errors++; $display("FAIL oe01 got %b exp 1", oe_out_n); end
    oe_n = 2'b10; #1;
    checks++; if (oe_out_n !== 1'b1) begin errors++; $display("FAIL oe10 got %b exp 1", oe_out_n); end
    checks++; if (q !== 8'h5A) begin errors++; $display("FAIL oe_q got %h exp 5a", q); end
    oe_n = 2'b11;
  endtask

  task automatic test_counter();
    load(8'hFE);
    mode = 3'b010;
    tick();
    checks++; if ({co, q} !== 9'h0FF) begin errors++; $display("FAIL inc1 got co=%b q=%h exp co=0 q=ff", co, q); end
    tick();
    checks++; if ({co, q} !== 9'h100) begin errors++; $display("FAIL inc_wrap got co=%b q=%h exp co=1 q=00", co, q); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL inc_zero got %b exp 1", zero); end
    mode = 3'b011;
    tick();
    checks++; if ({co, q} !== 9'h1FF) begin errors++; $display("FAIL dec_wrap got co=%b q=%h exp co=1 q=ff", co, q); end
    mode = 3'b000;
    tick();
    checks++; if ({co, q} !== 9'h1FF) begin errors++; $display("FAIL mode_hold got co=%b q=%h exp co=1 q=ff", co, q); end
    en_n = 1'b1; mode = 3'b011;
    tick();
    checks++; if ({co, q} !== 9'h1FF) begin errors++; $display("FAIL en_hold_co got co=%b q=%h exp co=1 q=ff", co, q); end
    en_n = 1'b0;
    tick();
    checks++; if ({co, q} !== 9'h0FE) begin errors++; $display("FAIL dec got co=%b q=%h exp co=0 q=fe", co, q); end
  endtask

  task automatic test_shift_rotate();
    load(8'b1000_0001);
    mode = 3'b100; ser_in = 1'b0;
    tick();
    checks++; if ({co, q} !== 9'b1_0000_0010) begin errors++; $display("FAIL shl got co=%b q=%b exp co=1 q=00000010", co, q); end
    mode = 3'b101; ser_in = 1'b1;
    tick();
    checks++; if ({co, q} !== 9'b0_1000_0001) begin errors++; $display("FAIL shr got co=%b q=%b exp co=0 q=10000001", co, q); end
    mode = 3'b110; ser_in = 1'b0;
    tick();
    checks++; if ({co, q} !== 9'b1_0000_0011) begin errors++; $display("FAIL rol got co=%b q=%b exp co=1 q=00000011", co, q); end
  endtask

  task automatic test_clear_priority();
    mode = 3'b111;
    tick();
    checks++; if ({co, q} !== 9'h0A5) begin errors++; $display("FAIL sync_clr got co=%b q=%h exp co=0 q=a5", co, q); end
    load(8'h10);
    mode = 3'b010;
    #3 clr_n = 1'b0;
    tick();
    checks++; if (q !== 8'hA5) begin errors++; $display("FAIL clr_vs_inc got %h exp a5", q); end
    clr_n = 1'b1;
    tick();
    checks++; if ({co, q} !== 9'h0A6) begin errors++; $display("FAIL post_release got co=%b q=%h exp co=0 q=a6", co, q); end
  endtask

  task automatic test_parity();
    logic p7, p3;
`ifdef BUS_REG_UNIVERSAL_PARITY_EN
    p7 = 1'b1; p3 = 1'b0;
`else
    p7 = 1'b0; p3 = 1'b0;
`endif
    load(8'h07);
    checks++; if (par !== p7) begin errors++; $display("FAIL par_07 got %b exp %b", par, p7); end
    load(8'h03);
    checks++; if (par !== p3) begin errors++; $display("FAIL par_03 got %b exp %b", par, p3); end
  endtask

  initial begin
    test_reset();
    test_load_enable();
    test_counter();
    test_shift_rotate();
    test_clear_priority();
    test_parity();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
